// File: rtl/csi_uport_init_seq.sv
// csi_uport_init_seq: command-driven register init sequencer with an AXI4-Lite master.
// Ports:
//   aclk, aresetn                      clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_op        command handshake; op 00 WRITE, 01 POLL, 10 WAIT, 11 illegal
//   cmd_addr/cmd_data/cmd_mask         register offset, write data or wait count, poll mask
//   aw*/w*/b*/ar*/r*                   AXI4-Lite master channels (one transaction at a time)
//   busy                               high while the sequencer is not idle
//   err_valid/err_code/err_sticky      error pulse, held code (01 resp, 10 timeout, 11 op), sticky flag
//   last_rdata                         data of the most recent completed read
module csi_uport_init_seq #(
  parameter logic [31:0] BASE_ADDR  = 32'h00A00000,
  parameter int unsigned POLL_MAX   = 1024,
  parameter int unsigned GAP_CYCLES = 50
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_mask,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        busy,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic        err_sticky,
  output logic [31:0] last_rdata
);

  localparam int unsigned CW = 32;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_POLL  = 2'b01;
  localparam logic [1:0] OP_WAIT  = 2'b10;

  localparam logic [1:0] ERR_RESP    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OP      = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_WAIT, S_GAP
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  poll_q, poll_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic [31:0]    mask_q, mask_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           awvalid_q, awvalid_d;
  logic           wvalid_q, wvalid_d;
  logic           bready_q, bready_d;
  logic           arvalid_q, arvalid_d;
  logic           rready_q, rready_d;
  logic           busy_q, busy_d;
  logic           err_valid_q, err_valid_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           err_sticky_q, err_sticky_d;
  logic [31:0]    last_rdata_q, last_rdata_d;

  logic aw_hs, w_hs;

  assign aw_hs = awvalid_q && awready;
  assign w_hs  = wvalid_q && wready;

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    poll_d       = poll_q;
    addr_d       = addr_q;
    data_d       = data_q;
    mask_d       = mask_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    err_valid_d  = 1'b0;
    err_code_d   = err_code_q;
    last_rdata_d = last_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d = BASE_ADDR + cmd_addr;
          data_d = cmd_data;
          mask_d = cmd_mask;
          cnt_d  = '0;
          poll_d = '0;
          case (cmd_op)
            OP_WRITE: begin
              state_d   = S_WR;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
            end
            OP_POLL: begin
              state_d   = S_RD_ADDR;
              arvalid_d = 1'b1;
            end
            OP_WAIT: state_d = S_WAIT;
            default: begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_OP;
            end
          endcase
        end
      end
      S_WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        // Leave once each channel has either already finished or finishes now.
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (bvalid) begin
          bready_d = 1'b0;
          state_d  = S_GAP;
          cnt_d    = '0;
          if (bresp != 2'b00) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_RESP;
          end
        end
      end
      S_RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (rvalid) begin
          rready_d     = 1'b0;
          last_rdata_d = rdata;
          poll_d       = poll_q + CW'(1);
          if (rresp != 2'b00) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_RESP;
          end
          if ((rdata & mask_q) == 32'd0) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end else if ((poll_q + CW'(1)) >= CW'(POLL_MAX)) begin
            // Timeout takes precedence over a bad response on the same read.
            err_valid_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = S_GAP;
            cnt_d       = '0;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WAIT: begin
        // A count of 0 still spends one cycle here.
        if ((cnt_q + CW'(1)) >= CW'(data_q[15:0])) state_d = S_IDLE;
        else                                       cnt_d   = cnt_q + CW'(1);
      end
      S_GAP: begin
        if ((cnt_q + CW'(1)) >= CW'(GAP_CYCLES)) state_d = S_IDLE;
        else                                     cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    err_sticky_d = err_sticky_q | err_valid_d;
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      poll_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      cmd_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= 2'b00;
      err_sticky_q <= 1'b0;
      last_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      poll_q       <= poll_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      cmd_ready_q  <= cmd_ready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      busy_q       <= busy_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_sticky_q <= err_sticky_d;
      last_rdata_q <= last_rdata_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign awvalid    = awvalid_q;
  assign awaddr     = addr_q;
  assign awprot     = 3'b000;
  assign wvalid     = wvalid_q;
  assign wdata      = data_q;
  assign wstrb      = 4'hF;
  assign bready     = bready_q;
  assign arvalid    = arvalid_q;
  assign araddr     = addr_q;
  assign arprot     = 3'b000;
  assign rready     = rready_q;
  assign busy       = busy_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_sticky = err_sticky_q;
  assign last_rdata = last_rdata_q;

endmodule

// File: tb/tb_csi_uport_init_seq.sv
// Testbench for csi_uport_init_seq: AXI4-Lite slave model with programmable delays and
// read data, handshake/error monitors, directed scenarios and a randomized command stream.
module tb_csi_uport_init_seq;

  localparam logic [31:0] BASE = 32'h00A00000;
  localparam int          GAP  = 50;
  localparam int          PMAX = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = '0, cmd_data = '0, cmd_mask = '0;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [31:0] awaddr, wdata, araddr, last_rdata;
  logic [31:0] rdata = '0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00, err_code;
  logic        busy, err_valid, err_sticky;

  int vectors = 0, miscompares = 0;

  always #5 aclk = ~aclk;

  csi_uport_init_seq #(.BASE_ADDR(BASE), .POLL_MAX(PMAX), .GAP_CYCLES(GAP)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .busy(busy), .err_valid(err_valid), .err_code(err_code),
    .err_sticky(err_sticky), .last_rdata(last_rdata)
  );

  // Slave configuration, written only by the stimulus process.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_base = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] rd_seq [0:7];

  // Monitor counters, sampled on rising edges (pre-update values).
  int          cyc = 0, aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  int          busy_n = 0, err_n = 0, valid_n = 0, conc_n = 0, drop_n = 0;
  logic [31:0] mon_awaddr = '0, mon_wdata = '0, mon_araddr = '0;
  logic [1:0]  mon_code = 2'b00;
  logic        aw_seen, w_seen, b_pend, r_pend, pv_aw, pv_w, pv_ar;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (busy) busy_n <= busy_n + 1;
    if (err_valid) begin err_n <= err_n + 1; mon_code <= err_code; end
    if (awvalid || wvalid || arvalid) valid_n <= valid_n + 1;
    if (arvalid && (awvalid || wvalid)) conc_n <= conc_n + 1;
    if (awvalid && awready) begin aw_n <= aw_n + 1; mon_awaddr <= awaddr; end
    if (wvalid && wready) begin w_n <= w_n + 1; mon_wdata <= wdata; end
    if (bvalid && bready) b_n <= b_n + 1;
    if (arvalid && arready) begin ar_n <= ar_n + 1; mon_araddr <= araddr; end
    if (rvalid && rready) r_n <= r_n + 1;
  end

  // Slave response bookkeeping and valid-stability tracking.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      pv_aw <= 1'b0; pv_w <= 1'b0; pv_ar <= 1'b0;
    end else begin
      if (pv_aw && !awvalid) drop_n <= drop_n + 1;
      if (pv_w && !wvalid)   drop_n <= drop_n + 1;
      if (pv_ar && !arvalid) drop_n <= drop_n + 1;
      pv_aw <= awvalid && !awready;
      pv_w  <= wvalid && !wready;
      pv_ar <= arvalid && !arready;
      if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
        b_pend <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        if (awvalid && awready) aw_seen <= 1'b1;
        if (wvalid && wready)   w_seen  <= 1'b1;
      end
      if (bvalid && bready)   b_pend <= 1'b0;
      if (arvalid && arready) r_pend <= 1'b1;
      if (rvalid && rready)   r_pend <= 1'b0;
    end
  end

  int aw_w = 0, w_w = 0, ar_w = 0;
  always @(negedge aclk) begin
    if (awvalid) begin awready = (aw_w >= aw_dly); aw_w++; end else begin awready = 1'b0; aw_w = 0; end
    if (wvalid)  begin wready  = (w_w >= w_dly);   w_w++;  end else begin wready  = 1'b0; w_w  = 0; end
    if (arvalid) begin arready = (ar_w >= ar_dly); ar_w++; end else begin arready = 1'b0; ar_w = 0; end
    bvalid = b_pend;
    bresp  = b_pend ? cfg_bresp : 2'b00;
    rvalid = r_pend;
    rdata  = r_pend ? rd_seq[(r_n - r_base) & 7] : 32'd0;
    rresp  = r_pend ? cfg_rresp : 2'b00;
  end

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] m, output int acc);
    int t = 0;
    @(negedge aclk);
    while (!cmd_ready && t < 3000) begin @(negedge aclk); t++; end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, t);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
    @(posedge aclk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge aclk);
    while (busy && t < 3000) begin @(negedge aclk); t++; end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_timeout: busy=%b, required 0", busy); end
  endtask

  function automatic logic [138:0] all_outs();
    return {cmd_ready, awvalid, wvalid, bready, arvalid, rready, busy, err_valid, err_code,
            err_sticky, awaddr, araddr, wdata, last_rdata};
  endfunction

  task automatic test_reset();
    logic [138:0] o;
    aresetn = 1'b0;
    #12;
    o = all_outs();
    vectors++;
    if (o !== '0) begin miscompares++; $display("FAIL reset_outs: got %h, required 0", o); end
    @(negedge aclk); aresetn = 1'b1; #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL ready_before_edge: got %b, required 0", cmd_ready); end
    @(posedge aclk); #1;
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL ready_after_edge: ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write();
    int sb, saw, sbn, se, acc;
    aw_dly = 3; w_dly = 0; cfg_bresp = 2'b00;
    sb = busy_n; saw = aw_n; sbn = b_n; se = err_n;
    send_cmd(2'b00, 32'h28, 32'h300, 32'h0, acc);
    vectors++;
    if (wstrb !== 4'hF || awprot !== 3'b000 || arprot !== 3'b000) begin
      miscompares++; $display("FAIL write_strb_prot: wstrb=%h awprot=%h arprot=%h, required f 0 0", wstrb, awprot, arprot);
    end
    wait_idle();
    vectors++;
    if (mon_awaddr !== 32'h00A00028 || mon_wdata !== 32'h300) begin
      miscompares++; $display("FAIL write_addr_data: awaddr=%h wdata=%h, required 00a00028 00000300", mon_awaddr, mon_wdata);
    end
    vectors++;
    if (aw_n - saw !== 1 || b_n - sbn !== 1) begin
      miscompares++; $display("FAIL write_handshakes: aw=%0d b=%0d, required 1 1", aw_n - saw, b_n - sbn);
    end
    vectors++;
    if (busy_n - sb !== 3 + 2 + GAP || err_n - se !== 0) begin
      miscompares++; $display("FAIL write_busy: busy=%0d errs=%0d, required %0d 0", busy_n - sb, err_n - se, 5 + GAP);
    end
  endtask

  task automatic test_poll();
    int sr, se, acc;
    ar_dly = 0; cfg_rresp = 2'b00;
    rd_seq[0] = 32'h1; rd_seq[1] = 32'h4; rd_seq[2] = 32'h0;
    for (int k = 3; k < 8; k++) rd_seq[k] = 32'h5;
    sr = r_n; se = err_n; r_base = r_n;
    send_cmd(2'b01, 32'h24, 32'h0, 32'h5, acc);
    wait_idle();
    vectors++;
    if (r_n - sr !== 3 || last_rdata !== 32'h0 || err_n - se !== 0 || mon_araddr !== 32'h00A00024) begin
      miscompares++; $display("FAIL poll_basic: reads=%0d last=%h errs=%0d araddr=%h, required 3 0 0 00a00024",
                              r_n - sr, last_rdata, err_n - se, mon_araddr);
    end
  endtask

  task automatic test_poll_timeout();
    int sr, se, acc;
    for (int k = 0; k < 8; k++) rd_seq[k] = 32'h1;
    sr = r_n; se = err_n; r_base = r_n;
    send_cmd(2'b01, 32'h10, 32'h0, 32'h1, acc);
    wait_idle();
    vectors++;
    if (r_n - sr !== PMAX || last_rdata !== 32'h1) begin
      miscompares++; $display("FAIL poll_timeout_reads: reads=%0d last=%h, required %0d 1", r_n - sr, last_rdata, PMAX);
    end
    vectors++;
    if (err_n - se !== 1 || mon_code !== 2'b10 || err_code !== 2'b10 || err_sticky !== 1'b1) begin
      miscompares++; $display("FAIL poll_timeout_err: pulses=%0d code=%b sticky=%b, required 1 10 1",
                              err_n - se, err_code, err_sticky);
    end
  endtask

  task automatic test_bresp_err();
    int sb, se, sbn, acc;
    aw_dly = 1; w_dly = 2; cfg_bresp = 2'b10;
    sb = busy_n; se = err_n; sbn = b_n;
    send_cmd(2'b00, 32'h40, 32'hDEAD, 32'h0, acc);
    wait_idle();
    cfg_bresp = 2'b00;
    vectors++;
    if (err_n - se !== 1 || err_code !== 2'b01 || b_n - sbn !== 1 || busy_n - sb !== 2 + 2 + GAP) begin
      miscompares++; $display("FAIL bresp_err: pulses=%0d code=%b b=%0d busy=%0d, required 1 01 1 %0d",
                              err_n - se, err_code, b_n - sbn, busy_n - sb, 4 + GAP);
    end
  endtask

  task automatic test_illegal();
    int sv, se, sb, acc;
    sv = valid_n; se = err_n; sb = busy_n;
    send_cmd(2'b11, 32'h4, 32'h4, 32'h4, acc);
    repeat (4) @(negedge aclk);
    vectors++;
    if (err_n - se !== 1 || err_code !== 2'b11 || valid_n - sv !== 0 || busy_n - sb !== 0) begin
      miscompares++; $display("FAIL illegal_op: pulses=%0d code=%b valids=%0d busy=%0d, required 1 11 0 0",
                              err_n - se, err_code, valid_n - sv, busy_n - sb);
    end
  endtask

  task automatic test_wait();
    int sb, acc;
    sb = busy_n;
    send_cmd(2'b10, 32'h0, 32'h5, 32'h0, acc);
    wait_idle();
    vectors++;
    if (busy_n - sb !== 5) begin miscompares++; $display("FAIL wait5: busy=%0d, required 5", busy_n - sb); end
    sb = busy_n;
    send_cmd(2'b10, 32'h0, 32'hFFFF_0000, 32'h0, acc);
    wait_idle();
    vectors++;
    if (busy_n - sb !== 1) begin miscompares++; $display("FAIL wait0: busy=%0d, required 1", busy_n - sb); end
  endtask

  task automatic test_back_to_back();
    int a1, a2, saw;
    aw_dly = 0; w_dly = 1; cfg_bresp = 2'b00;
    saw = aw_n;
    send_cmd(2'b00, 32'h8, 32'h11, 32'h0, a1);
    send_cmd(2'b00, 32'hC, 32'h22, 32'h0, a2);
    wait_idle();
    vectors++;
    if (a2 - a1 !== (1 + 2 + GAP) + 1 || aw_n - saw !== 2 || mon_wdata !== 32'h22) begin
      miscompares++; $display("FAIL back_to_back: spacing=%0d aw=%0d wdata=%h, required %0d 2 00000022",
                              a2 - a1, aw_n - saw, mon_wdata, GAP + 4);
    end
  endtask

  task automatic test_reset_mid();
    int sb, sbn, se, acc;
    logic [138:0] o;
    aw_dly = 10; w_dly = 0;
    send_cmd(2'b00, 32'h30, 32'h77, 32'h0, acc);
    repeat (3) @(negedge aclk);
    vectors++;
    if (awvalid !== 1'b1) begin miscompares++; $display("FAIL mid_awvalid: got %b, required 1", awvalid); end
    #2 aresetn = 1'b0;
    #1 o = all_outs();
    vectors++;
    if (o !== '0) begin miscompares++; $display("FAIL mid_reset_outs: got %h, required 0", o); end
    @(negedge aclk); aresetn = 1'b1;
    aw_dly = 1;
    sb = busy_n; sbn = b_n; se = err_n;
    send_cmd(2'b00, 32'h34, 32'h88, 32'h0, acc);
    wait_idle();
    vectors++;
    if (mon_awaddr !== BASE + 32'h34 || b_n - sbn !== 1 || busy_n - sb !== 1 + 2 + GAP ||
        err_n - se !== 0 || err_sticky !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_write: awaddr=%h b=%0d busy=%0d errs=%0d sticky=%b",
                              mon_awaddr, b_n - sbn, busy_n - sb, err_n - se, err_sticky);
    end
  endtask

  task automatic test_random();
    logic [1:0]  exp_code = 2'b00;
    logic        exp_sticky = 1'b0;
    int          sel, sb, se, sr, sv, acc, n, reads, exp_pulses;
    logic [31:0] a, d, m, last;
    logic        done, bad;
    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 9);
      a = $urandom; d = $urandom;
      sb = busy_n; se = err_n; sr = r_n; sv = valid_n;
      if (sel <= 3) begin
        aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4);
        cfg_bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        send_cmd(2'b00, a, d, 32'h0, acc);
        wait_idle();
        exp_pulses = (cfg_bresp != 2'b00) ? 1 : 0;
        if (exp_pulses != 0) begin exp_code = 2'b01; exp_sticky = 1'b1; end
        n = ((aw_dly > w_dly) ? aw_dly : w_dly) + 2 + GAP;
        vectors++;
        if (mon_awaddr !== BASE + a || mon_wdata !== d || busy_n - sb !== n) begin
          miscompares++; $display("FAIL rnd_write[%0d]: awaddr=%h wdata=%h busy=%0d, required %h %h %0d",
                                  it, mon_awaddr, mon_wdata, busy_n - sb, BASE + a, d, n);
        end
      end else if (sel <= 7) begin
        ar_dly = $urandom_range(0, 3);
        m = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
        bad = ($urandom_range(0, 3) == 0);
        cfg_rresp = bad ? 2'b10 : 2'b00;
        for (int k = 0; k < 8; k++)
          rd_seq[k] = ($urandom_range(0, 2) == 0) ? ($urandom & ~m) : ($urandom | (m & (~m + 32'd1)));
        if (bad) rd_seq[$urandom_range(0, PMAX - 1)] = $urandom & ~m;
        reads = 0; done = 1'b0; last = 32'h0;
        for (int k = 0; k < PMAX; k++) begin
          if (!done) begin
            reads++; last = rd_seq[k];
            if ((rd_seq[k] & m) == 32'h0) done = 1'b1;
          end
        end
        exp_pulses = (bad ? reads : 0) + (done ? 0 : 1);
        if (bad) exp_code = 2'b01;
        if (!done) exp_code = 2'b10;
        if (exp_pulses != 0) exp_sticky = 1'b1;
        r_base = r_n;
        send_cmd(2'b01, a, d, m, acc);
        wait_idle();
        cfg_rresp = 2'b00;
        vectors++;
        if (r_n - sr !== reads || last_rdata !== last || mon_araddr !== BASE + a) begin
          miscompares++; $display("FAIL rnd_poll[%0d]: reads=%0d last=%h araddr=%h, required %0d %h %h",
                                  it, r_n - sr, last_rdata, mon_araddr, reads, last, BASE + a);
        end
      end else if (sel == 8) begin
        n = $urandom_range(0, 12);
        exp_pulses = 0;
        send_cmd(2'b10, a, {d[31:16], 16'(n)}, 32'h0, acc);
        wait_idle();
        vectors++;
        if (busy_n - sb !== ((n == 0) ? 1 : n)) begin
          miscompares++; $display("FAIL rnd_wait[%0d]: busy=%0d, required %0d", it, busy_n - sb, (n == 0) ? 1 : n);
        end
      end else begin
        exp_pulses = 1; exp_code = 2'b11; exp_sticky = 1'b1;
        send_cmd(2'b11, a, d, 32'h0, acc);
        repeat (3) @(negedge aclk);
        vectors++;
        if (valid_n - sv !== 0 || busy_n - sb !== 0) begin
          miscompares++; $display("FAIL rnd_illegal[%0d]: valids=%0d busy=%0d, required 0 0", it, valid_n - sv, busy_n - sb);
        end
      end
      vectors++;
      if (err_n - se !== exp_pulses || err_code !== exp_code || err_sticky !== exp_sticky) begin
        miscompares++; $display("FAIL rnd_err[%0d]: pulses=%0d code=%b sticky=%b, required %0d %b %b",
                                it, err_n - se, err_code, err_sticky, exp_pulses, exp_code, exp_sticky);
      end
    end
  endtask

  task automatic test_protocol();
    vectors++;
    if (conc_n !== 0 || drop_n !== 0) begin
      miscompares++; $display("FAIL axi_protocol: concurrent=%0d dropped=%0d, required 0 0", conc_n, drop_n);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) rd_seq[k] = 32'h0;
    test_reset();
    test_write();
    test_poll();
    test_poll_timeout();
    test_bresp_err();
    test_illegal();
    test_wait();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csi_uport_init_seq.md
CSI_UPORT_INIT_SEQ -- requirements
Module: csi_uport_init_seq

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h00A00000, offset added to every cmd_addr to form the AXI address.
REQ-002 SHALL provide parameter POLL_MAX, default 1024, maximum reads per POLL command before timeout.
REQ-003 SHALL provide parameter GAP_CYCLES, default 50, idle cycles inserted after every completed WRITE or POLL command.
REQ-004 aclk  in  1  single clock for all logic; reset is asynchronous and active-low.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; a command transfers when both are high on a rising aclk edge.
REQ-007 cmd_op  in  2  00 WRITE, 01 POLL, 10 WAIT, 11 illegal.
REQ-008 cmd_addr / cmd_data / cmd_mask  in  32 / 32 / 32  register offset, write data or WAIT cycle count, POLL mask.
REQ-009 AXI4-Lite master  out/in: awvalid, awready, awaddr[31:0], awprot[2:0], wvalid, wready, wdata[31:0], wstrb[3:0], bvalid, bready, bresp[1:0], arvalid, arready, araddr[31:0], arprot[2:0], rvalid, rready, rdata[31:0], rresp[1:0].
REQ-010 busy  out  1  high whenever the state is not IDLE.
REQ-011 err_valid / err_code / err_sticky  out  1 / 2 / 1  error pulse, code (01 bad resp, 10 poll timeout, 11 illegal op), sticky flag.
REQ-012 last_rdata  out  32  data of the most recent completed read.

Function
REQ-013 States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, WAIT, GAP.
REQ-014 cmd_ready SHALL be high only in IDLE; the command fields are registered on acceptance.
REQ-015 WRITE: IDLE->WR; awvalid and wvalid assert together the next cycle; each deasserts independently after its own handshake; once both have completed -> WR_RESP.
REQ-016 awaddr = BASE_ADDR + cmd_addr (32-bit wrap), wdata = cmd_data, wstrb = 4'hF, awprot = arprot = 3'b000.
REQ-017 WR_RESP: bready high; on bvalid -> GAP.
REQ-018 POLL: RD_ADDR asserts arvalid with araddr = BASE_ADDR + cmd_addr until arready, then RD_DATA with rready high.
REQ-019 On rvalid: last_rdata <= rdata and the poll counter increments.
  - (rdata & cmd_mask) == 0 -> GAP.
  - counter == POLL_MAX -> err_code 10, then GAP.
  - otherwise -> RD_ADDR.
REQ-020 POLL with cmd_mask == 0 SHALL complete after exactly one read.
REQ-021 WAIT: stay cmd_data[15:0] cycles in WAIT, then -> IDLE with no GAP; a count of 0 returns to IDLE the next cycle.
REQ-022 Illegal op: err_code 11 pulses and the state returns to IDLE with no AXI activity.
REQ-023 bresp or rresp != 00: err_code 01; the command still completes normally (a POLL continues polling).
REQ-024 err_valid SHALL be a one-cycle pulse with err_code held until the next error; err_sticky sets on any error.
REQ-025 GAP counts GAP_CYCLES cycles then -> IDLE; GAP_CYCLES = 0 SHALL go to IDLE the next cycle.
REQ-026 valid signals SHALL never deassert before their handshake, and SHALL NOT depend combinationally on ready.
REQ-027 At most one AXI transaction SHALL be outstanding; awvalid/wvalid SHALL never be concurrent with arvalid.
REQ-028 Minimum back-to-back WRITE spacing = handshake cycles + GAP_CYCLES + 1 (IDLE).

Reset
REQ-029 Asynchronous assertion of aresetn SHALL force within the same cycle:
  - state IDLE, all counters 0;
  - all AXI valid/ready outputs 0, addresses and data 0;
  - cmd_ready 0, busy 0, err_valid 0, err_code 00, err_sticky 0, last_rdata 0.
REQ-030 cmd_ready SHALL rise on the first aclk edge after deassertion; reset mid-transaction abandons the transaction with no replay.

Verification
REQ-031 WRITE off 0x28 data 0x300, awready/wready delayed 3 and 0 cycles -> awaddr 0x00A00028, wdata 0x300, one B handshake, busy for handshake+50+ cycles.
REQ-032 POLL off 0x24 mask 0x5, slave returns 0x1, 0x4, 0x0 -> exactly 3 reads, last_rdata 0x0, no error.
REQ-033 POLL with POLL_MAX=4, slave always returns 0x1 -> 4 reads, err_code 10 pulsed once, err_sticky 1.
REQ-034 WRITE with bresp 10 -> err_code 01, GAP entered; cmd_op 11 -> err 11, zero AXI valids.
REQ-035 WAIT cmd_data 5 -> busy exactly 5 cycles; WAIT 0 -> busy 1 cycle.
REQ-036 aresetn low while awvalid is high -> all outputs 0 immediately; next command runs cleanly.
